// File: rtl/nettlp_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nettlp_cmd_pkg
//  Purpose  : Shared types and constants for the NetTLP command path:
//             the command FIFO entry layout, opcode values, and the header
//             constants used by the ingress parser.
//  Revision : 1.0  initial release
// ============================================================================
package nettlp_cmd_pkg;

    // One entry of the command input FIFO feeding nettlp_cmd_core.
    typedef struct packed {
        logic [7:0]  opcode;
        logic [15:0] dwaddr;
        logic [31:0] data;
    } FIFO_NETTLP_CMD_T;

    localparam logic [7:0] NETTLP_OPC_NOP    = 8'h00;
    localparam logic [7:0] NETTLP_OPC_REG_RD = 8'h01;
    localparam logic [7:0] NETTLP_OPC_REG_WR = 8'h02;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;

    // Beats of 8 bytes needed to reach byte 49, the last command byte.
    localparam int NETTLP_CMD_MIN_BEATS = 7;

endpackage
`default_nettype wire

// File: rtl/nettlp_cmd_rx.sv
`default_nettype none
// ============================================================================
//  Module   : nettlp_cmd_rx
//  Purpose  : Ingress parser for NetTLP register-access command packets.
//             Checks the Ethernet/IPv4/UDP header beat by beat, captures
//             opcode/dwaddr/data from the UDP payload and writes one command
//             FIFO entry per valid frame. Every other frame is dropped and
//             counted. The MAC is never backpressured.
//  Ports    : clk, rst                 clock, synchronous active-high reset
//             s_axis_*                 64-bit MAC receive stream
//             local_ip                 adapter IPv4 address (host order)
//             fifo_cmd_o_wr_en/full/din  command FIFO write side
//             cnt_accepted/cnt_dropped   wrapping frame counters
//  Revision : 1.0  initial release
// ============================================================================
module nettlp_cmd_rx
    import nettlp_cmd_pkg::*;
#(
    parameter logic [15:0] CMD_UDP_PORT = 16'h3775,
    parameter int          MIN_BEATS    = NETTLP_CMD_MIN_BEATS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      s_axis_tdata,
    input  logic [7:0]       s_axis_tkeep,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tuser,
    output logic             s_axis_tready,
    input  logic [31:0]      local_ip,
    output logic             fifo_cmd_o_wr_en,
    input  logic             fifo_cmd_o_full,
    output FIFO_NETTLP_CMD_T fifo_cmd_o_din,
    output logic [31:0]      cnt_accepted,
    output logic [31:0]      cnt_dropped
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RECV = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    // Index of the earliest beat on which tlast may complete a command.
    localparam logic [2:0] c_LAST_MIN = 3'(MIN_BEATS - 1);

    logic [1:0]       r_state;
    logic [2:0]       r_beat_cnt;
    logic             r_wr_en;
    FIFO_NETTLP_CMD_T r_hold;
    logic [31:0]      r_cnt_acc;
    logic [31:0]      r_cnt_drop;

    logic             w_field_ok;
    logic             w_pass;
    logic [2:0]       w_cnt_inc;

    // tkeep carries no information here, and byte 43 (tdata[31:24] on
    // beat 5) is the reserved payload byte; those bits are the only ones
    // never looked at.
    logic w_unused;
    assign w_unused = ^{s_axis_tkeep, s_axis_tdata[31:24]};

    assign s_axis_tready    = ~rst;
    assign fifo_cmd_o_wr_en = r_wr_en;
    // The holding register is the FIFO data: beat 5 of the next frame is
    // at least 5 cycles after the write strobe, so it is stable when read.
    assign fifo_cmd_o_din   = r_hold;
    assign cnt_accepted     = r_cnt_acc;
    assign cnt_dropped      = r_cnt_drop;

    assign w_cnt_inc = (r_beat_cnt == 3'd7) ? 3'd7 : r_beat_cnt + 3'd1;

    // Header checks on the beat that carries each field. Byte n of the
    // frame is at tdata[8*(n%8) +: 8] of beat n/8; multi-byte fields are
    // big-endian on the wire.
    always_comb begin
        w_field_ok = 1'b1;
        case (r_beat_cnt)
            3'd1: w_field_ok = ({s_axis_tdata[39:32], s_axis_tdata[47:40]} == ETHERTYPE_IPV4)
                            && (s_axis_tdata[55:48] == IP_VER_IHL);
            3'd2: w_field_ok = (s_axis_tdata[63:56] == IP_PROTO_UDP);
            3'd3: w_field_ok = ({s_axis_tdata[55:48], s_axis_tdata[63:56]} == local_ip[31:16]);
            3'd4: w_field_ok = ({s_axis_tdata[7:0], s_axis_tdata[15:8]} == local_ip[15:0])
                            && ({s_axis_tdata[39:32], s_axis_tdata[47:40]} == CMD_UDP_PORT);
            default: w_field_ok = 1'b1;
        endcase
    end

    assign w_pass = (r_beat_cnt >= c_LAST_MIN) && w_field_ok
                 && !s_axis_tuser && !fifo_cmd_o_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_beat_cnt <= 3'd0;
            r_wr_en    <= 1'b0;
            r_hold     <= '0;
            r_cnt_acc  <= 32'd0;
            r_cnt_drop <= 32'd0;
        end else begin
            r_wr_en <= 1'b0;
            if (s_axis_tvalid) begin
                case (r_state)
                    S_IDLE: begin
                        if (s_axis_tlast) begin
                            r_cnt_drop <= r_cnt_drop + 32'd1;
                        end else begin
                            r_state    <= S_RECV;
                            r_beat_cnt <= 3'd1;
                        end
                    end
                    S_RECV: begin
                        if (r_beat_cnt == 3'd5) begin
                            r_hold.opcode      <= s_axis_tdata[23:16];
                            r_hold.dwaddr      <= {s_axis_tdata[39:32], s_axis_tdata[47:40]};
                            r_hold.data[31:16] <= {s_axis_tdata[55:48], s_axis_tdata[63:56]};
                        end
                        if (r_beat_cnt == 3'd6) begin
                            r_hold.data[15:0]  <= {s_axis_tdata[7:0], s_axis_tdata[15:8]};
                        end
                        if (s_axis_tlast) begin
                            if (w_pass) begin
                                r_wr_en   <= 1'b1;
                                r_cnt_acc <= r_cnt_acc + 32'd1;
                            end else begin
                                r_cnt_drop <= r_cnt_drop + 32'd1;
                            end
                            r_state    <= S_IDLE;
                            r_beat_cnt <= 3'd0;
                        end else begin
                            if (!w_field_ok) begin
                                r_state <= S_DROP;
                            end
                            r_beat_cnt <= w_cnt_inc;
                        end
                    end
                    S_DROP: begin
                        if (s_axis_tlast) begin
                            r_cnt_drop <= r_cnt_drop + 32'd1;
                            r_state    <= S_IDLE;
                            r_beat_cnt <= 3'd0;
                        end else begin
                            r_beat_cnt <= w_cnt_inc;
                        end
                    end
                    default: begin
                        r_state    <= S_IDLE;
                        r_beat_cnt <= 3'd0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nettlp_cmd_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nettlp_cmd_rx
//  Purpose  : Self-checking bench for nettlp_cmd_rx. Frames are built as byte
//             arrays; a byte-level reference model decides accept/drop and
//             pushes expected FIFO entries (with due cycle) into a queue that
//             a separate monitor pops whenever the write strobe is seen.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nettlp_cmd_rx;
    import nettlp_cmd_pkg::*;

    localparam logic [31:0] c_IP = 32'hC0A80A01;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [63:0]      s_axis_tdata = '0;
    logic [7:0]       s_axis_tkeep = '0;
    logic             s_axis_tvalid = 1'b0;
    logic             s_axis_tlast = 1'b0;
    logic             s_axis_tuser = 1'b0;
    logic             s_axis_tready;
    logic [31:0]      local_ip = c_IP;
    logic             fifo_cmd_o_wr_en;
    logic             fifo_cmd_o_full = 1'b0;
    FIFO_NETTLP_CMD_T fifo_cmd_o_din;
    logic [31:0]      cnt_accepted;
    logic [31:0]      cnt_dropped;

    nettlp_cmd_rx dut (
        .clk              (clk),
        .rst              (rst),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tkeep     (s_axis_tkeep),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tuser     (s_axis_tuser),
        .s_axis_tready    (s_axis_tready),
        .local_ip         (local_ip),
        .fifo_cmd_o_wr_en (fifo_cmd_o_wr_en),
        .fifo_cmd_o_full  (fifo_cmd_o_full),
        .fifo_cmd_o_din   (fifo_cmd_o_din),
        .cnt_accepted     (cnt_accepted),
        .cnt_dropped      (cnt_dropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        FIFO_NETTLP_CMD_T cmd;
        int               due;
    } exp_t;

    exp_t       sbq[$];
    int         n_total  = 0;
    int         n_pass   = 0;
    int         ncyc     = 0;
    int         exp_acc  = 0;
    int         exp_drop = 0;
    logic [7:0] frame[0:79];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Random filler everywhere, then the fields of a well-formed command.
    task automatic build_valid(input logic [7:0] opc, input logic [15:0] addr, input logic [31:0] data);
        for (int i = 0; i < 80; i++) frame[i] = 8'($urandom);
        frame[12] = 8'h08; frame[13] = 8'h00; frame[14] = 8'h45; frame[23] = 8'd17;
        frame[30] = c_IP[31:24]; frame[31] = c_IP[23:16];
        frame[32] = c_IP[15:8];  frame[33] = c_IP[7:0];
        frame[36] = 8'h37; frame[37] = 8'h75;
        frame[42] = opc;
        frame[44] = addr[15:8]; frame[45] = addr[7:0];
        frame[46] = data[31:24]; frame[47] = data[23:16];
        frame[48] = data[15:8];  frame[49] = data[7:0];
    endtask

    // Reference decision for a frame whose byte 0 is frame[off].
    task automatic model_commit(input int off, input int nb, input bit tu, input bit fu);
        bit   ok;
        exp_t e;
        ok = (nb >= 7) && (!tu) && (!fu)
          && ({frame[off+12], frame[off+13]} == 16'h0800)
          && (frame[off+14] == 8'h45) && (frame[off+23] == 8'd17)
          && ({frame[off+30], frame[off+31], frame[off+32], frame[off+33]} == local_ip)
          && ({frame[off+36], frame[off+37]} == 16'h3775);
        if (ok) begin
            e.cmd = {frame[off+42], frame[off+44], frame[off+45],
                     frame[off+46], frame[off+47], frame[off+48], frame[off+49]};
            e.due = ncyc + 1;
            sbq.push_back(e);
            exp_acc++;
        end else begin
            exp_drop++;
        end
    endtask

    // Sends beats start..start+nb-1 of frame[]. With cut set, the last beat
    // carries no tlast and the model is not consulted.
    task automatic send_frame(input int start, input int nb, input bit tu, input bit fu,
                              input bit gaps, input bit cut);
        bit last;
        for (int b = 0; b < nb; b++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    s_axis_tvalid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            for (int k = 0; k < 8; k++) s_axis_tdata[8*k +: 8] = frame[8*(start+b)+k];
            last            = (b == nb - 1) && !cut;
            s_axis_tvalid   = 1'b1;
            s_axis_tlast    = last;
            s_axis_tkeep    = last ? 8'($urandom) : 8'hFF;
            s_axis_tuser    = last ? tu : 1'($urandom);
            fifo_cmd_o_full = last ? fu : 1'($urandom);
            @(posedge clk);
            if (last) model_commit(8 * start, nb, tu, fu);
            #1;
        end
        s_axis_tvalid   = 1'b0;
        s_axis_tlast    = 1'b0;
        s_axis_tuser    = 1'b0;
        fifo_cmd_o_full = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string name);
        chk({name, "_accepted"}, 64'(cnt_accepted), 64'(exp_acc));
        chk({name, "_dropped"},  64'(cnt_dropped),  64'(exp_drop));
    endtask

    // Monitor: every write strobe must match the oldest expected entry, on
    // exactly its due cycle; an entry whose cycle passes unseen is missing.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!rst) begin
                if (fifo_cmd_o_wr_en) begin
                    if (sbq.size() == 0) begin
                        chk("wr_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = sbq.pop_front();
                        chk("din", 64'(fifo_cmd_o_din), 64'(e.cmd));
                        chk("wr_latency", 64'(ncyc), 64'(e.due));
                    end
                end else if (sbq.size() > 0 && sbq[0].due < ncyc) begin
                    chk("wr_missing", 64'd0, 64'd1);
                    void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        int idx[10] = '{12, 13, 14, 23, 30, 31, 32, 33, 36, 37};
        int mode;
        int nb;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_tready",   64'(s_axis_tready),    64'd0);
        chk("rst_wr_en",    64'(fifo_cmd_o_wr_en), 64'd0);
        chk("rst_din",      64'(fifo_cmd_o_din),   64'd0);
        chk("rst_accepted", 64'(cnt_accepted),     64'd0);
        chk("rst_dropped",  64'(cnt_dropped),      64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("tready_run", 64'(s_axis_tready), 64'd1);
        idle(1);

        // Reference command frame.
        build_valid(NETTLP_OPC_REG_WR, 16'h0005, 32'hC0A80A09);
        send_frame(0, 7, 0, 0, 0, 0);
        idle(3);
        chk("t1_accepted_abs", 64'(cnt_accepted), 64'd1);
        check_counters("t1");

        // Header mismatches: port, ethertype, destination IP.
        build_valid(NETTLP_OPC_REG_WR, 16'h0005, 32'hC0A80A09);
        frame[37] = 8'h76;
        send_frame(0, 7, 0, 0, 0, 0);
        build_valid(NETTLP_OPC_REG_WR, 16'h0005, 32'hC0A80A09);
        frame[12] = 8'h86; frame[13] = 8'hDD;
        send_frame(0, 7, 0, 0, 0, 0);
        build_valid(NETTLP_OPC_REG_WR, 16'h0005, 32'hC0A80A09);
        frame[33] = 8'h02;
        send_frame(0, 7, 0, 0, 0, 0);
        idle(3);
        chk("t2_dropped_abs", 64'(cnt_dropped), 64'd3);
        check_counters("t2");

        // Bad FCS, 5-beat runt, 1-beat runt.
        build_valid(NETTLP_OPC_REG_RD, 16'h0010, 32'h11223344);
        send_frame(0, 7, 1, 0, 0, 0);
        send_frame(0, 5, 0, 0, 0, 0);
        send_frame(0, 1, 0, 0, 0, 0);
        idle(3);
        chk("t3_dropped_abs", 64'(cnt_dropped), 64'd6);
        check_counters("t3");

        // FIFO full on commit, then a normal frame.
        build_valid(NETTLP_OPC_REG_WR, 16'h0100, 32'hDEADBEEF);
        send_frame(0, 7, 0, 1, 0, 0);
        build_valid(NETTLP_OPC_REG_WR, 16'h0101, 32'hCAFEF00D);
        send_frame(0, 7, 0, 0, 0, 0);
        idle(3);
        check_counters("t4");

        // Back-to-back frames, then the same with random tvalid gaps.
        for (int g = 0; g < 2; g++) begin
            for (int f = 0; f < 4; f++) begin
                build_valid(8'($urandom), 16'($urandom), $urandom);
                send_frame(0, 7, 0, 0, g[0], 0);
            end
        end
        idle(3);
        check_counters("t5");

        // Randomized mix of good and faulty frames.
        for (int f = 0; f < 40; f++) begin
            build_valid(8'($urandom), 16'($urandom), $urandom);
            mode = $urandom_range(0, 5);
            nb   = $urandom_range(7, 9);
            if (mode == 2) frame[idx[$urandom_range(0, 9)]] ^= 8'($urandom_range(1, 255));
            if (mode == 5) nb = $urandom_range(1, 6);
            send_frame(0, nb, (mode == 3), (mode == 4), 1'($urandom), 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(3);
        check_counters("t6");

        // Reset in the middle of a valid frame; the leftover beats arrive
        // as a new frame and must be rejected, the next frame accepted.
        build_valid(NETTLP_OPC_REG_WR, 16'h0aaa, 32'h01020304);
        send_frame(0, 3, 0, 0, 0, 1);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        exp_acc  = 0;
        exp_drop = 0;
        check_counters("t7_reset");
        send_frame(3, 4, 0, 0, 0, 0);
        build_valid(NETTLP_OPC_REG_RD, 16'h0bbb, 32'h05060708);
        send_frame(0, 7, 0, 0, 0, 0);
        idle(4);
        check_counters("t7_after");

        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
